layer_loader: RTL and testbench

//  Upstream feeder for the layer stage. On start_i, reads one x vector and one

---
 rtl/layer_loader.sv | 143 ++++++++++++++
 tb/tb_layer_loader.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/layer_loader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// layer_loader : fetches x vector, NxN weights (and biases when
//                LAYER_LOADER_BIAS_EN is defined) from ram for the layer stage
// Revision     : 1.0
// ----------------------------------------------------------------------------
module layer_loader #(
  parameter int WORD_SIZE   = 16,
  parameter int NEURON_SIZE = 4,
  parameter int ADDR_WIDTH  = 16
) (
  input  logic                                                  clk_i,
  input  logic                                                  rst_n_i,
  input  logic                                                  start_i,
  input  logic [ADDR_WIDTH-1:0]                                 base_addr_i,
  output logic [ADDR_WIDTH-1:0]                                 ram_addr_o,
  input  logic [WORD_SIZE-1:0]                                  ram_data_i,
  output logic [NEURON_SIZE-1:0][NEURON_SIZE-1:0][WORD_SIZE-1:0] x_o,
  output logic [NEURON_SIZE-1:0][NEURON_SIZE-1:0][WORD_SIZE-1:0] weights_o,
  output logic [NEURON_SIZE-1:0][WORD_SIZE-1:0]                 bias_o,
  output logic                                                  en_o,
  output logic                                                  busy_o,
  output logic                                                  done_o
);

  localparam int N = NEURON_SIZE;
`ifdef LAYER_LOADER_BIAS_EN
  localparam int R = N + N*N + N;
`else
  localparam int R = N + N*N;
`endif
  localparam int CW = $clog2(R + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_DRAIN = 3'd2,
    S_FIRE  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                        state_q, state_d;
  logic [ADDR_WIDTH-1:0]         addr_q, addr_d;
  logic [CW-1:0]                 issue_q, issue_d;
  logic [CW-1:0]                 cap_q, cap_d;
  logic                          cap_vld_q, cap_vld_d;
  logic [N-1:0][WORD_SIZE-1:0]   x_q, x_d;
  logic [N*N-1:0][WORD_SIZE-1:0] w_q, w_d;
`ifdef LAYER_LOADER_BIAS_EN
  logic [N-1:0][WORD_SIZE-1:0]   b_q, b_d;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      issue_q   <= '0;
      cap_q     <= '0;
      cap_vld_q <= 1'b0;
      x_q       <= '0;
      w_q       <= '0;
`ifdef LAYER_LOADER_BIAS_EN
      b_q       <= '0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      issue_q   <= issue_d;
      cap_q     <= cap_d;
      cap_vld_q <= cap_vld_d;
      x_q       <= x_d;
      w_q       <= w_d;
`ifdef LAYER_LOADER_BIAS_EN
      b_q       <= b_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    issue_d   = issue_q;
    // Capture trails issue by one cycle to match the ram read latency.
    cap_d     = issue_q;
    cap_vld_d = (state_q == S_FETCH);
    x_d       = x_q;
    w_d       = w_q;
`ifdef LAYER_LOADER_BIAS_EN
    b_d       = b_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_FETCH;
          addr_d  = base_addr_i;
          issue_d = '0;
        end
      end
      S_FETCH: begin
        if (issue_q == CW'(R - 1)) begin
          state_d = S_DRAIN;
        end else begin
          issue_d = issue_q + CW'(1);
          addr_d  = addr_q + ADDR_WIDTH'(1);
        end
      end
      S_DRAIN: state_d = S_FIRE;
      S_FIRE:  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (cap_vld_q) begin
      for (int j = 0; j < N; j++)
        if (cap_q == CW'(j)) x_d[j] = ram_data_i;
      for (int j = 0; j < N*N; j++)
        if (cap_q == CW'(N + j)) w_d[j] = ram_data_i;
`ifdef LAYER_LOADER_BIAS_EN
      for (int j = 0; j < N; j++)
        if (cap_q == CW'(N + N*N + j)) b_d[j] = ram_data_i;
`endif
    end
  end

  assign ram_addr_o = addr_q;
  assign busy_o     = (state_q != S_IDLE);
  assign en_o       = (state_q == S_FIRE);
  assign done_o     = (state_q == S_DONE);
  assign weights_o  = w_q;

  for (genvar n = 0; n < N; n++) begin : g_bcast
    assign x_o[n] = x_q;
  end

`ifdef LAYER_LOADER_BIAS_EN
  assign bias_o = b_q;
`else
  assign bias_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_layer_loader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_layer_loader : scoreboard bench for layer_loader (LAYER_LOADER_BIAS_EN aware)
// Revision        : 1.0
// ----------------------------------------------------------------------------
module tb_layer_loader;

  localparam int W  = 16;
  localparam int N  = 4;
  localparam int AW = 16;
`ifdef LAYER_LOADER_BIAS_EN
  localparam int R = N + N*N + N;
`else
  localparam int R = N + N*N;
`endif

  logic                          clk = 1'b0;
  logic                          rst_n = 1'b0;
  logic                          start = 1'b0;
  logic [AW-1:0]                 base = '0;
  logic [AW-1:0]                 ram_addr;
  logic [W-1:0]                  ram_data = '0;
  logic [N-1:0][N-1:0][W-1:0]    x_o, w_o;
  logic [N-1:0][W-1:0]           b_o;
  logic                          en_o, busy_o, done_o;

  logic [W-1:0] mem [0:65535];

  typedef struct packed {
    logic [N-1:0][N-1:0][W-1:0] x;
    logic [N-1:0][N-1:0][W-1:0] w;
    logic [N-1:0][W-1:0]        b;
    int                         en_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t e_mon;
  int   cyc = 0;
  int   n_chk = 0, n_err = 0;
  int   en_cnt = 0, done_cnt = 0, exp_loads = 0;
  int   last_en = -100;

  layer_loader #(.WORD_SIZE(W), .NEURON_SIZE(N), .ADDR_WIDTH(AW)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .base_addr_i(base),
    .ram_addr_o(ram_addr), .ram_data_i(ram_data), .x_o(x_o),
    .weights_o(w_o), .bias_o(b_o), .en_o(en_o), .busy_o(busy_o),
    .done_o(done_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) ram_data <= mem[ram_addr];

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ram[B+i] = v+i for the x/weight region, 0xB000+n for the bias words.
  task automatic fill(input logic [AW-1:0] b, input logic [W-1:0] v);
    for (int i = 0; i < N + N*N + N; i++) begin
      logic [AW-1:0] a;
      a = b + AW'(i);
      mem[a] = (i < N + N*N) ? v + W'(i) : 16'hB000 + W'(i - N - N*N);
    end
  endtask

  task automatic push_exp(input logic [W-1:0] v, input int t0);
    exp_t e;
    for (int n = 0; n < N; n++) begin
      for (int k = 0; k < N; k++) begin
        e.x[n][k] = v + W'(k);
        e.w[n][k] = v + W'(N + n*N + k);
      end
`ifdef LAYER_LOADER_BIAS_EN
      e.b[n] = 16'hB000 + W'(n);
`else
      e.b[n] = '0;
`endif
    end
    e.en_cyc = t0 + R + 2;
    sb.push_back(e);
    exp_loads++;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic start_pulse(input logic [AW-1:0] b, output int t0);
    @(negedge clk);
    base  = b;
    start = 1'b1;
    t0    = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy_o) begin
      n_chk++;
      n_err++;
      $display("FAIL idle_timeout: busy_o still 1 after %0d cycles", n);
    end
  endtask

  always @(negedge clk) begin
    if (en_o) begin
      en_cnt++;
      last_en = cyc;
      if (sb.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_en: en_o=1 at cycle %0d, expected none", cyc);
      end else begin
        e_mon = sb.pop_front();
        chk("en_cycle", 512'(cyc), 512'(e_mon.en_cyc));
        chk("x_o", 512'(x_o), 512'(e_mon.x));
        chk("weights_o", 512'(w_o), 512'(e_mon.w));
        chk("bias_o", 512'(b_o), 512'(e_mon.b));
      end
    end
    if (done_o) begin
      done_cnt++;
      chk("done_cycle", 512'(cyc), 512'(last_en + 1));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1;

    // Reset held two cycles.
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_busy", 512'(busy_o), 512'(0));
    chk("rst_en_done", 512'({en_o, done_o}), 512'(0));
    chk("rst_addr", 512'(ram_addr), 512'(0));
    chk("rst_buses", 512'({x_o, w_o, b_o}), 512'(0));

    // Basic load.
    fill(16'h0100, 16'h1000);
    start_pulse(16'h0100, t0);
    push_exp(16'h1000, t0);
    wait_idle();

    // Address wrap, checking the issue sequence.
    fill(16'hFFFE, 16'h2000);
    start_pulse(16'hFFFE, t0);
    push_exp(16'h2000, t0);
    for (int k = 1; k <= R; k++) begin
      wait_cyc(t0 + k);
      chk("wrap_addr", 512'(ram_addr), 512'(16'(16'hFFFE + k - 1)));
    end
    wait_idle();
    chk("addr_hold", 512'(ram_addr), 512'(16'(16'hFFFE + R - 1)));

    // start_i pulses mid-load and during FIRE are ignored.
    fill(16'h0300, 16'h3000);
    start_pulse(16'h0300, t0);
    push_exp(16'h3000, t0);
    wait_cyc(t0 + 5);      start = 1'b1;
    wait_cyc(t0 + 6);      start = 1'b0;
    wait_cyc(t0 + R + 2);  start = 1'b1;
    wait_cyc(t0 + R + 3);  start = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);
    chk("no_requeue", 512'(busy_o), 512'(0));

    // Reset mid-load discards the partial load.
    fill(16'h0400, 16'h4000);
    start_pulse(16'h0400, t0);
    wait_cyc(t0 + 10);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy", 512'(busy_o), 512'(0));
    chk("abort_buses", 512'({x_o, w_o, b_o}), 512'(0));
    chk("abort_addr", 512'(ram_addr), 512'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    fill(16'h0500, 16'h5000);
    start_pulse(16'h0500, t0);
    push_exp(16'h5000, t0);
    wait_idle();

    // start_i held high: back-to-back loads with one IDLE cycle between.
    fill(16'h0600, 16'h6000);
    fill(16'h0700, 16'h7000);
    @(negedge clk);
    base  = 16'h0600;
    start = 1'b1;
    t0    = cyc;
    push_exp(16'h6000, t0);
    wait_cyc(t0 + R + 3);
    base = 16'h0700;
    t1   = t0 + R + 4;
    push_exp(16'h7000, t1);
    wait_cyc(t1 + 1);
    start = 1'b0;
    wait_idle();

    repeat (4) @(negedge clk);
    chk("en_count", 512'(en_cnt), 512'(exp_loads));
    chk("done_count", 512'(done_cnt), 512'(exp_loads));
    chk("sb_empty", 512'(sb.size()), 512'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire
